// File: rtl/alu_multicycle.sv
// Registered ALU with iterative unsigned MUL/DIVU/REMU behind a start/busy/done handshake.
// Optional macro ALU_MULH_EN adds MULHU (0101) and widens the product path to 2*WIDTH bits.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [3:0]       ALU_ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_out,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
`ifdef ALU_MULH_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_MULH = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1000;
  localparam logic [3:0] OP_REMU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic { IDLE, ITER } state_t;
  typedef enum logic [1:0] { K_MUL, K_MULH, K_DIV, K_REM } kind_t;

  state_t           state_q;
  kind_t            kind_q, kind_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, carry_q, ovf_q, zero_q;
  logic [WIDTH-1:0] out_q;

  logic [PW-1:0]    mcand_q, prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q, rem_d, quo_d;

  logic             iter_req;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] iter_res;

  // Single-cycle datapath works straight off the inputs on the accept edge.
  always_comb begin
    add_w    = {1'b0, A_in} + {1'b0, B_in};
    sub_w    = {1'b0, A_in} + {1'b0, ~B_in} + {{WIDTH{1'b0}}, 1'b1};
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    iter_req = 1'b0;
    kind_d   = K_MUL;
    case (ALU_ctrl)
      OP_AND:  sc_res = A_in & B_in;
      OP_OR:   sc_res = A_in | B_in;
      OP_NOR:  sc_res = ~(A_in | B_in);
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (sub_w[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A_in) < $signed(B_in))};
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (A_in == B_in)};
      OP_MUL:  begin iter_req = 1'b1; kind_d = K_MUL; end
`ifdef ALU_MULH_EN
      OP_MULH: begin iter_req = 1'b1; kind_d = K_MULH; end
`endif
      OP_DIVU: begin iter_req = 1'b1; kind_d = K_DIV; end
      OP_REMU: begin iter_req = 1'b1; kind_d = K_REM; end
      default: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (add_w[WIDTH-1] != A_in[WIDTH-1]);
      end
    endcase
  end

  // One shift-add step and one restoring-division step per cycle; divide by zero
  // naturally yields an all-ones quotient and a remainder equal to A.
  logic [WIDTH:0] shifted, trial;
  logic           ge;
  always_comb begin
    prod_d  = prod_q + (mplier_q[0] ? mcand_q : '0);
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, div_q};
    trial   = shifted - {1'b0, div_q};
    rem_d   = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ge};
    case (kind_q)
      K_MUL:   iter_res = prod_d[WIDTH-1:0];
      K_MULH:  iter_res = prod_d[PW-1:PW-WIDTH];
      K_DIV:   iter_res = quo_d;
      default: iter_res = rem_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      kind_q   <= K_MUL;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (iter_req) begin
              state_q  <= ITER;
              busy_q   <= 1'b1;
              kind_q   <= kind_d;
              cnt_q    <= '0;
              mcand_q  <= PW'(A_in);
              mplier_q <= B_in;
              prod_q   <= '0;
              rem_q    <= '0;
              quo_q    <= A_in;
              div_q    <= B_in;
            end else begin
              out_q   <= sc_res;
              carry_q <= sc_c;
              ovf_q   <= sc_v;
              zero_q  <= ~|sc_res;
              done_q  <= 1'b1;
            end
          end
        end
        ITER: begin
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          prod_q   <= prod_d;
          rem_q    <= rem_d;
          quo_q    <= quo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= iter_res;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= ~|iter_res;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ALU_out   = out_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32).
module tb_alu_multicycle;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] A_in, B_in;
  logic [3:0]  ALU_ctrl;
  logic        busy, done, carry_out, zero, overflow;
  logic [31:0] ALU_out;

  int n_chk = 0;
  int n_err = 0;
  int lat, bcnt, dcnt;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .A_in(A_in), .B_in(B_in),
    .ALU_ctrl(ALU_ctrl), .busy(busy), .done(done), .ALU_out(ALU_out),
    .carry_out(carry_out), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after acceptance, wait for done.
  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALU_ctrl = ctrl; A_in = a; B_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A_in = ~a; B_in = ~b; ALU_ctrl = 4'b0000;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      lat++;
      @(negedge clk);
    end
    if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic chk_res(input string tag, input logic [31:0] r, input logic c, input logic v);
    chk({tag, "_out"}, {32'd0, ALU_out}, {32'd0, r});
    chk({tag, "_flags"}, {61'd0, carry_out, overflow, zero}, {61'd0, c, v, (r == 32'd0)});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; A_in = '0; B_in = '0; ALU_ctrl = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {58'd0, busy, done, ALU_out == 32'd0, carry_out, overflow, zero},
        {58'd0, 6'b001001});
    reset = 1'b0;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1);
    chk("add_ovf_lat", {32'd0, lat[15:0], bcnt[15:0]}, 64'd0);
    chk_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1);
    chk_res("add_carry", 32'h0, 1'b1, 1'b0);
    run_op(4'b0110, 32'd5, 32'd5);
    chk_res("sub_eq", 32'h0, 1'b1, 1'b0);
    run_op(4'b0110, 32'd3, 32'd5);
    chk_res("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(4'b0110, 32'h8000_0000, 32'h1);
    chk_res("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
    chk_res("and", 32'h00F0_1200, 1'b0, 1'b0);
    run_op(4'b0001, 32'hF000_0001, 32'h0000_0100);
    chk_res("or", 32'hF000_0101, 1'b0, 1'b0);
    run_op(4'b1100, 32'hF000_0000, 32'h0000_000F);
    chk_res("nor", 32'h0FFF_FFF0, 1'b0, 1'b0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h1);
    chk_res("slt_neg", 32'h1, 1'b0, 1'b0);
    run_op(4'b0111, 32'h1, 32'hFFFF_FFFF);
    chk_res("slt_pos", 32'h0, 1'b0, 1'b0);
    run_op(4'b1111, 32'h1234, 32'h1234);
    chk_res("eq", 32'h1, 1'b0, 1'b0);
    run_op(4'b0100, 32'h10, 32'h20);
    chk_res("undef_add", 32'h30, 1'b0, 1'b0);

    // carry was left at 1 by the next ADD; MUL must clear it
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h2);
    run_op(4'b0011, 32'h0001_0000, 32'h0001_0003);
    chk("mul_busy_cycles", {32'd0, bcnt}, 64'd32);
    chk_res("mul", 32'h0003_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_after_done", {31'd0, done, ALU_out}, {32'd0, 32'h0003_0000});

    run_op(4'b0101, 32'h0001_0000, 32'h0001_0003);
`ifdef ALU_MULH_EN
    chk("mulhu_busy_cycles", {32'd0, bcnt}, 64'd32);
    chk_res("mulhu", 32'h0000_0001, 1'b0, 1'b0);
`else
    chk("code5_add_lat", {32'd0, bcnt}, 64'd0);
    chk_res("code5_add", 32'h0002_0003, 1'b0, 1'b0);
`endif

    run_op(4'b1000, 32'd100, 32'd7);
    chk("divu_busy_cycles", {32'd0, bcnt}, 64'd32);
    chk_res("divu", 32'd14, 1'b0, 1'b0);
    run_op(4'b1001, 32'd100, 32'd7);
    chk_res("remu", 32'd2, 1'b0, 1'b0);
    run_op(4'b1000, 32'd9, 32'd0);
    chk_res("divu_by0", 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(4'b1001, 32'd9, 32'd0);
    chk_res("remu_by0", 32'd9, 1'b0, 1'b0);
    run_op(4'b1000, 32'hFFFF_FFFF, 32'h10);
    chk_res("divu_big", 32'h0FFF_FFFF, 1'b0, 1'b0);

    // AND pulsed while DIVU busy must be dropped
    @(negedge clk);
    ALU_ctrl = 4'b1000; A_in = 32'd100; B_in = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0; lat = 0; dcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == 5) begin ALU_ctrl = 4'b0000; A_in = 32'hF; B_in = 32'h3; start = 1'b1; end
      else start = 1'b0;
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
    chk("ignored_start_busy", {32'd0, bcnt}, 64'd32);
    chk_res("ignored_start", 32'd14, 1'b0, 1'b0);

    // start on the done cycle is accepted
    ALU_ctrl = 4'b0010; A_in = 32'd2; B_in = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", {63'd0, done}, 64'd1);
    chk_res("b2b", 32'd5, 1'b0, 1'b0);

    // reset mid-MUL
    @(negedge clk);
    ALU_ctrl = 4'b0011; A_in = 32'h1234; B_in = 32'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_mul_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", {58'd0, busy, done, ALU_out == 32'd0, carry_out, overflow, zero},
        {58'd0, 6'b001001});
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("no_done_after_abort", {32'd0, dcnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
